// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: writer FSM encoding,
// default output addressing, byte/word widths and pixel saturation limits.
package conv_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam int unsigned OUT_BASE_DEF = 0;
  localparam logic [WORD_W-1:0] END_WORD_DEF = 16'h00FF;

  localparam int unsigned SAT_MIN = 0;
  localparam int unsigned SAT_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } wr_state_t;

endpackage

// File: rtl/relu_sat8.sv
// ReLU plus unsigned 8-bit saturation of a signed accumulator value.
// Ports: acc (signed ACC_W input), px8 (8-bit pixel, combinational).
module relu_sat8
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [BYTE_W-1:0] px8
);

  // Anything above the low byte (sign excluded) means the value exceeds 255.
  logic over_c;
  assign over_c = |acc[ACC_W-2:BYTE_W];

  always_comb begin
    px8 = acc[BYTE_W-1:0];
    if (acc[ACC_W-1]) begin
      px8 = BYTE_W'(SAT_MIN);
    end else if (over_c) begin
      px8 = BYTE_W'(SAT_MAX);
    end
  end

endmodule

// File: rtl/conv_output_writer.sv
// Converts convolution results to 8-bit pixels, packs pixel pairs into 16-bit
// words and writes them to the output SRAM. Rows flush odd pixels; frame end
// flushes any pending byte, appends a terminator word and pulses wr_done.
// Ports: clk/reset; init, px_valid, px_data, px_last_in_row, frame_done in;
// px_ready, SRAM write address/data/enable, words_written, wr_busy, wr_done,
// addr_wrap_err out (all registered).
module conv_output_writer
  import conv_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 12,
  parameter int unsigned        ACC_W    = 16,
  parameter logic [ADDR_W-1:0]  OUT_BASE = ADDR_W'(OUT_BASE_DEF),
  parameter logic [WORD_W-1:0]  END_WORD = END_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              px_valid,
  input  logic [ACC_W-1:0]  px_data,
  input  logic              px_last_in_row,
  input  logic              frame_done,
  output logic              px_ready,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [WORD_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] words_written,
  output logic              wr_busy,
  output logic              wr_done,
  output logic              addr_wrap_err
);

  wr_state_t         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              half;
  logic [BYTE_W-1:0] held;

  logic [BYTE_W-1:0] px8_c;
  logic              wr_fire_c;
  logic [WORD_W-1:0] wr_word_c;

  relu_sat8 #(.ACC_W(ACC_W)) u_relu_sat8 (
    .acc (px_data),
    .px8 (px8_c)
  );

  // Word to write this cycle, if any; init overrides all activity.
  always_comb begin
    wr_fire_c = 1'b0;
    wr_word_c = '0;
    if (!init) begin
      case (state)
        ST_RUN: begin
          if (px_valid) begin
            if (half) begin
              wr_fire_c = 1'b1;
              wr_word_c = {px8_c, held};
            end else if (px_last_in_row) begin
              wr_fire_c = 1'b1;
              wr_word_c = {BYTE_W'(0), px8_c};
            end
          end
        end
        ST_TERM: begin
          wr_fire_c = 1'b1;
          wr_word_c = half ? {BYTE_W'(0), held} : END_WORD;
        end
        default: ;
      endcase
    end
  end

  // FSM, packing state and registered SRAM/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      wr_ptr                 <= '0;
      half                   <= 1'b0;
      held                   <= '0;
      px_ready               <= 1'b0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      words_written          <= '0;
      wr_busy                <= 1'b0;
      wr_done                <= 1'b0;
      addr_wrap_err          <= 1'b0;
    end else begin
      dut_sram_write_enable <= 1'b0;
      wr_done               <= 1'b0;

      if (wr_fire_c) begin
        dut_sram_write_enable  <= 1'b1;
        dut_sram_write_address <= wr_ptr;
        dut_sram_write_data    <= wr_word_c;
        wr_ptr                 <= wr_ptr + ADDR_W'(1);
        words_written          <= words_written + ADDR_W'(1);
        if (wr_ptr == '1) begin
          addr_wrap_err <= 1'b1;
        end
      end

      if (init) begin
        state                  <= ST_RUN;
        wr_ptr                 <= OUT_BASE;
        dut_sram_write_address <= OUT_BASE;
        words_written          <= '0;
        addr_wrap_err          <= 1'b0;
        half                   <= 1'b0;
        px_ready               <= 1'b1;
        wr_busy                <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (px_valid) begin
              if (half || px_last_in_row) begin
                half <= 1'b0;
              end else begin
                held <= px8_c;
                half <= 1'b1;
              end
            end
            if (frame_done) begin
              state    <= ST_TERM;
              px_ready <= 1'b0;
            end
          end
          ST_TERM: begin
            // A pending byte takes one extra TERM cycle before the terminator.
            if (half) begin
              half <= 1'b0;
            end else begin
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            wr_done <= 1'b1;
            wr_busy <= 1'b0;
            state   <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/conv_output_writer.md
Name: conv_output_writer

Overview:
- Write-side counterpart to the convolution sequencer's input-read path.
- Accepts one convolution result per cycle from the conv modules and converts each to an 8-bit pixel (ReLU + saturate).
- Packs two pixels per 16-bit word and drives the output SRAM write port.
- Row ends flush odd pixels; frame end appends a terminator word and raises a done pulse back to the controller.

Parameters:
- OUT_BASE, 12'h000, first output SRAM word address after init.
- END_WORD, 16'h00FF, terminator word written after the last row of a frame.
- ADDR_W, 12, SRAM address width.
- ACC_W, 16, signed width of incoming convolution results.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  pulse; loads write address with OUT_BASE, clears count and error, enters RUN.
- px_valid  in  1  px_data valid this cycle.
- px_data  in  ACC_W  signed convolution result.
- px_last_in_row  in  1  qualifies px_valid; this pixel ends an output row.
- frame_done  in  1  pulse; all rows delivered.
- px_ready  out  1  writer accepts pixels (high only in RUN).
- dut_sram_write_address  out  ADDR_W  registered write address.
- dut_sram_write_data  out  16  registered write data.
- dut_sram_write_enable  out  1  registered, one-cycle write strobe.
- words_written  out  ADDR_W  words written since init, terminator included.
- wr_busy  out  1  high from init until the DONE cycle.
- wr_done  out  1  one-cycle pulse after the terminator write.
- addr_wrap_err  out  1  sticky; write address wrapped past all-ones.

Behaviour:
- All outputs reset to 0: addresses, data, enable, count, busy, done, error, px_ready. State resets to IDLE.
- Reset is asynchronous and active-high. Reset mid-frame abandons the pending byte and all state.
- FSM states: IDLE, RUN, TERM, DONE.
  - IDLE -> RUN on init.
  - RUN -> TERM on frame_done.
  - TERM -> DONE after one cycle.
  - DONE -> IDLE after one cycle.
  - init in any non-reset state restarts: address = OUT_BASE, count = 0, error cleared, pending byte dropped, state = RUN.
- Pixel conversion: px_data < 0 -> 8'h00; px_data > 255 -> 8'hFF; else px_data[7:0]. Combinational before packing.
- Packing:
  - First pixel of a pair is held in the low byte; a half flag is set.
  - The second pixel forms {px8, held}.
  - The write is registered: enable is high the cycle after the second pixel is accepted.
- Row end: px_last_in_row with half flag clear writes {8'h00, px8} the next cycle and leaves half clear. Rows never share a word.
- Write side effects: after each write, the address increments by 1 and words_written increments by 1.
- Address wrap: address all-ones -> 0 sets addr_wrap_err. The error stays set until init or reset.
- frame_done in the same cycle as px_valid: the pixel is processed first, then the FSM moves to TERM.
- frame_done with half flag set (no row end seen): the pending byte is written as {8'h00, held} in the first TERM cycle. END_WORD is written the following cycle, so TERM lasts 2 cycles in this case.
- TERM writes END_WORD at the current address and increments address and count.
- DONE: wr_done = 1 for one cycle; wr_busy deasserts in the same cycle.
- px_valid outside RUN is ignored (px_ready = 0). frame_done outside RUN is ignored.
- Maximum one write per cycle; back-to-back pairs sustain one write every 2 cycles.

Decomposition:
- Shared package conv_pkg:
  - FSM state encoding.
  - OUT_BASE and END_WORD defaults.
  - Byte/word widths.
  - Saturation limits 0 and 255.
- One sub-module, relu_sat8: purely combinational ACC_W -> 8-bit conversion. It is reused by the conv datapath and unit-tested alone.
- Packing, address and FSM logic live in conv_output_writer.

Test Plan:
- Pack pair: init; pixels 16'h0012, 16'h0034 -> one write, addr 0, data 16'h3412, enable one cycle, the cycle after the second pixel.
- Saturation and row end: pixels 16'hFFF0, 16'h0150, 16'h0007 (last_in_row) -> writes 16'hFF00 at addr 0, then 16'h0007 at addr 1.
- Frame end: 4 pixels then frame_done -> 2 data words, END_WORD 16'h00FF at addr 2, wr_done one cycle later, words_written = 3, wr_busy low.
- Overlap: px_valid with last_in_row and frame_done in the same cycle, odd pixel count -> partial word written, then END_WORD, then wr_done.
- Wrap: OUT_BASE = 12'hFFF; 4 pixels -> writes at FFF then 000, addr_wrap_err = 1. A second init clears it.
- Reset mid-pair: one pixel accepted, reset asserted asynchronously -> all outputs 0 immediately. After init, next pixels pack from the low byte with no stale data.
